// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one full-subtractor cell and a borrow flop; start/busy/done handshake.
// Optional signed-overflow output `ovf` is built when SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] shadow;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic x_bit;
  logic y_bit;
  logic diff_bit;
  logic br_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    x_bit    = sa[0];
    y_bit    = sb[0];
    diff_bit = x_bit ^ y_bit ^ br;
    br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br);
  end

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // busy/done are registered from the previous state, so they trail the state by one edge;
  // this places done in the last busy cycle and lets start be taken in the cycle right after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      shadow <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bo     <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= (state != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
`ifdef SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          shadow <= {diff_bit, shadow[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          d     <= shadow;
          bo    <= br;
          done  <= 1'b1;
          state <= IDLE;
`ifdef SUB_OVF_EN
          ovf   <= (a_msb != b_msb) && (shadow[WIDTH-1] != a_msb);
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and wait for its done; latency counted in edges from the accept edge.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_ovf);
    int lat;
    int ndone;
    logic [W-1:0] got_d;
    logic got_bo;
    logic got_ovf;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    ndone = 0;
    got_d = '0;
    got_bo = 1'b0;
    got_ovf = 1'b0;
    for (int k = 1; k <= W + 6; k++) begin
      tick();
      if (done) begin
        ndone++;
        lat = k;
        got_d = d;
        got_bo = bo;
`ifdef SUB_OVF_EN
        got_ovf = ovf;
`endif
      end
    end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_lat"}, lat, W + 1);
    chk({tag, "_d"}, int'(got_d), int'(exp_d));
    chk({tag, "_bo"}, int'(got_bo), int'(exp_bo));
`ifdef SUB_OVF_EN
    chk({tag, "_ovf"}, int'(got_ovf), int'(exp_ovf));
`else
    if (got_ovf != exp_ovf && exp_ovf === 1'bx) $display("note: ovf unused");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int done_n;
    int done_at;
    int cyc;
    int prev;
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] diff;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_bo", int'(bo), 0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", int'(ovf), 0);
`endif
    rst = 1'b0;
    tick();

    // 5-3: busy profile and done position
    a = 8'd5;
    b = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_after_accept", int'(busy), 0);
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
        chk("t1_d", int'(d), 8'h02);
        chk("t1_bo", int'(bo), 0);
        chk("t1_busy_with_done", int'(busy), 1);
      end
    end
    chk("t1_busy_cycles", busy_n, 9);
    chk("t1_done_count", done_n, 1);
    chk("t1_done_at", done_at, 9);
    chk("t1_d_hold", int'(d), 8'h02);

    run_op("t2", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    run_op("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Re-pulsed start and operand changes during RUN must be ignored
    a = 8'h00;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_n = 0;
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
      end
      if (k == 6) start = 1'b0;
      if (k < 9) chk("t4_d_stable", int'(d), 8'h7F);
      tick();
      if (done) begin
        done_n++;
        done_at = k;
        chk("t4_d", int'(d), 8'h01);
        chk("t4_bo", int'(bo), 1);
`ifdef SUB_OVF_EN
        chk("t4_ovf", int'(ovf), 0);
`endif
      end
    end
    chk("t4_done_count", done_n, 1);
    chk("t4_done_at", done_at, 9);

    // Reset in the middle of RUN aborts the op
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_d", int'(d), 0);
    chk("t5_bo", int'(bo), 0);
    rst = 1'b0;
    done_n = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (done) done_n++;
    end
    chk("t5_no_done", done_n, 0);
    run_op("t5b", 8'd9, 8'd9, 8'h00, 1'b0, 1'b0);

    // Random pairs, start held high; new operands are presented right after each done
    ra = 8'($urandom);
    rb = 8'($urandom);
    a = ra;
    b = rb;
    start = 1'b1;
    cyc = 0;
    prev = -1;
    n = 0;
    while (n < 1000 && cyc < 20000) begin
      tick();
      cyc++;
      if (done) begin
        diff = ra - rb;
        chk("rnd_d", int'(d), int'(diff));
        chk("rnd_bo", int'(bo), (ra < rb) ? 1 : 0);
`ifdef SUB_OVF_EN
        chk("rnd_ovf", int'(ovf),
            ((ra[W-1] != rb[W-1]) && (diff[W-1] != ra[W-1])) ? 1 : 0);
`endif
        if (n > 0) chk("rnd_gap", cyc - prev, W + 2);
        prev = cyc;
        n++;
        ra = 8'($urandom);
        rb = 8'($urandom);
        a = ra;
        b = rb;
      end
    end
    start = 1'b0;
    chk("rnd_done_count", n, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
